// File: rtl/emperor_axi_lite_master.sv
// AXI4-Lite initiator: turns a single-outstanding command/response port into AXI-Lite
// read and write transactions. Every AXI output is a register; VALIDs never look at READY.
module emperor_axi_lite_master #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  output logic                  in_transaction,
  output logic                  transaction_type,
  output logic [ADDR_W-1:0]     M_AXI_awaddr,
  output logic [2:0]            M_AXI_awprot,
  output logic                  M_AXI_awvalid,
  input  logic                  M_AXI_awready,
  output logic [DATA_W-1:0]     M_AXI_wdata,
  output logic [DATA_W/8-1:0]   M_AXI_wstrb,
  output logic                  M_AXI_wvalid,
  input  logic                  M_AXI_wready,
  input  logic [1:0]            M_AXI_bresp,
  input  logic                  M_AXI_bvalid,
  output logic                  M_AXI_bready,
  output logic [ADDR_W-1:0]     M_AXI_araddr,
  output logic [2:0]            M_AXI_arprot,
  output logic                  M_AXI_arvalid,
  input  logic                  M_AXI_arready,
  input  logic [DATA_W-1:0]     M_AXI_rdata,
  input  logic [1:0]            M_AXI_rresp,
  input  logic                  M_AXI_rvalid,
  output logic                  M_AXI_rready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]          state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_write_q, rsp_write_d;
  logic                in_trans_q, in_trans_d;
  logic                ttype_q, ttype_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    in_trans_d  = in_trans_q;
    ttype_d     = ttype_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          ttype_d     = cmd_write;
          in_trans_d  = 1'b1;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        // AW and W complete independently; bready opens only once both have.
        if (awvalid_q && M_AXI_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && M_AXI_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = M_AXI_bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && M_AXI_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = M_AXI_rdata;
          rsp_resp_d  = M_AXI_rresp;
          rsp_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          in_trans_d  = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_write_q <= 1'b0;
      in_trans_q  <= 1'b0;
      ttype_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
      in_trans_q  <= in_trans_d;
      ttype_q     <= ttype_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_resp         = rsp_resp_q;
  assign rsp_write        = rsp_write_q;
  assign in_transaction   = in_trans_q;
  assign transaction_type = ttype_q;
  assign M_AXI_awaddr     = addr_q;
  assign M_AXI_awprot     = PROT;
  assign M_AXI_awvalid    = awvalid_q;
  assign M_AXI_wdata      = wdata_q;
  assign M_AXI_wstrb      = wstrb_q;
  assign M_AXI_wvalid     = wvalid_q;
  assign M_AXI_bready     = bready_q;
  assign M_AXI_araddr     = addr_q;
  assign M_AXI_arprot     = PROT;
  assign M_AXI_arvalid    = arvalid_q;
  assign M_AXI_rready     = rready_q;

endmodule

// File: tb/tb_emperor_axi_lite_master.sv
// Directed and randomised bench for emperor_axi_lite_master with a word-addressed slave
// memory on the AXI side and an independent reference memory fed from the commands.
module tb_emperor_axi_lite_master;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        in_transaction, transaction_type;
  logic [31:0] M_AXI_awaddr, M_AXI_wdata, M_AXI_araddr, M_AXI_rdata = '0;
  logic [2:0]  M_AXI_awprot, M_AXI_arprot;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_awvalid, M_AXI_awready = 1'b0, M_AXI_wvalid, M_AXI_wready = 1'b0;
  logic [1:0]  M_AXI_bresp = '0, M_AXI_rresp = '0;
  logic        M_AXI_bvalid = 1'b0, M_AXI_bready;
  logic        M_AXI_arvalid, M_AXI_arready = 1'b0, M_AXI_rvalid = 1'b0, M_AXI_rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  always #5 aclk = ~aclk;

  emperor_axi_lite_master dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .in_transaction(in_transaction), .transaction_type(transaction_type),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot),
    .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
    .M_AXI_araddr(M_AXI_araddr), .M_AXI_arprot(M_AXI_arprot),
    .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One full transaction: command, AXI slave side with the given delays, response.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int a_d, input int w_d, input int r_d,
                         input logic [1:0] resp, input int rsp_d, input logic pend,
                         output int aw_cyc, output int w_cyc);
    int n;
    logic aw_done, w_done, aw_hs, w_hs, got, hs;
    logic [31:0] seen_addr, seen_data, exp_rdata, hold_rdata;
    logic [3:0]  seen_strb, idx;
    logic [1:0]  hold_resp;
    logic        hold_write;
    aw_cyc = 0; w_cyc = 0; n = 0;
    aw_done = 1'b0; w_done = 1'b0; got = 1'b0;
    seen_addr = '0; seen_data = '0; seen_strb = '0;
    idx = addr[5:2];
    exp_rdata = wr ? 32'h0 : ref_mem[idx];
    if (wr) ref_mem[idx] = merge(ref_mem[idx], wdata, strb);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    while (!cmd_ready && n < 20) begin step(); n++; end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("in_transaction_set", in_transaction, 1'b1);
    check("transaction_type", transaction_type, wr);
    check("cmd_ready_busy", cmd_ready, 1'b0);
    n = 0;
    if (wr) begin
      check("arvalid_on_write", M_AXI_arvalid, 1'b0);
      while (!got && n < 50) begin
        check("bready_gate", M_AXI_bready, aw_done & w_done);
        if (aw_done) check("awvalid_drop", M_AXI_awvalid, 1'b0);
        else begin
          aw_cyc++;
          check("awvalid_hold", M_AXI_awvalid, 1'b1);
          check("awaddr", M_AXI_awaddr, addr);
        end
        if (w_done) check("wvalid_drop", M_AXI_wvalid, 1'b0);
        else begin
          w_cyc++;
          check("wvalid_hold", M_AXI_wvalid, 1'b1);
          check("wdata", M_AXI_wdata, wdata);
          check("wstrb", M_AXI_wstrb, strb);
        end
        M_AXI_awready = !aw_done && (aw_cyc > a_d);
        M_AXI_wready  = !w_done && (w_cyc > w_d);
        M_AXI_bvalid  = (n >= r_d);
        M_AXI_bresp   = resp;
        aw_hs = M_AXI_awready && M_AXI_awvalid;
        w_hs  = M_AXI_wready && M_AXI_wvalid;
        hs    = M_AXI_bvalid && M_AXI_bready;
        if (aw_hs) seen_addr = M_AXI_awaddr;
        if (w_hs) begin seen_data = M_AXI_wdata; seen_strb = M_AXI_wstrb; end
        step();
        aw_done = aw_done | aw_hs;
        w_done  = w_done | w_hs;
        got = hs;
        n++;
      end
      M_AXI_awready = 1'b0; M_AXI_wready = 1'b0; M_AXI_bvalid = 1'b0;
      check("b_handshake", got, 1'b1);
      check("bready_after_b", M_AXI_bready, 1'b0);
      if (got) slv_mem[seen_addr[5:2]] = merge(slv_mem[seen_addr[5:2]], seen_data, seen_strb);
    end else begin
      check("awvalid_on_read", M_AXI_awvalid, 1'b0);
      while (!got && n < 50) begin
        check("rready_gate", M_AXI_rready, aw_done);
        if (aw_done) check("arvalid_drop", M_AXI_arvalid, 1'b0);
        else begin
          aw_cyc++;
          check("arvalid_hold", M_AXI_arvalid, 1'b1);
          check("araddr", M_AXI_araddr, addr);
        end
        M_AXI_arready = !aw_done && (aw_cyc > a_d);
        M_AXI_rvalid  = aw_done && (w_cyc >= r_d);
        M_AXI_rdata   = slv_mem[seen_addr[5:2]];
        M_AXI_rresp   = resp;
        aw_hs = M_AXI_arready && M_AXI_arvalid;
        hs    = M_AXI_rvalid && M_AXI_rready;
        if (aw_hs) seen_addr = M_AXI_araddr;
        if (aw_done) w_cyc++;
        step();
        aw_done = aw_done | aw_hs;
        got = hs;
        n++;
      end
      M_AXI_arready = 1'b0; M_AXI_rvalid = 1'b0;
      check("r_handshake", got, 1'b1);
      check("rready_after_r", M_AXI_rready, 1'b0);
    end
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_write", rsp_write, wr);
    check("rsp_resp", rsp_resp, resp);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    hold_rdata = rsp_rdata; hold_resp = rsp_resp; hold_write = rsp_write;
    for (int k = 0; k < rsp_d; k++) begin
      if (pend) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1000_0008;
      end
      step();
      check("rsp_hold_valid", rsp_valid, 1'b1);
      check("rsp_hold_rdata", rsp_rdata, hold_rdata);
      check("rsp_hold_resp", rsp_resp, hold_resp);
      check("rsp_hold_write", rsp_write, hold_write);
      check("cmd_ready_in_rsp", cmd_ready, 1'b0);
      check("in_transaction_rsp", in_transaction, 1'b1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_clear", rsp_valid, 1'b0);
    check("in_transaction_clear", in_transaction, 1'b0);
    check("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  initial begin
    int aw_c, w_c;
    logic        wr;
    logic [3:0]  ridx, rstrb;
    logic [31:0] rdat;
    for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end

    // Reset state
    step(); step();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_awvalid", M_AXI_awvalid, 1'b0);
    check("rst_wvalid", M_AXI_wvalid, 1'b0);
    check("rst_arvalid", M_AXI_arvalid, 1'b0);
    check("rst_bready", M_AXI_bready, 1'b0);
    check("rst_rready", M_AXI_rready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_write}, 35'h0);
    check("rst_in_transaction", in_transaction, 1'b0);
    check("rst_transaction_type", transaction_type, 1'b0);
    check("rst_awaddr", M_AXI_awaddr, 32'h0);
    check("rst_prot", {M_AXI_awprot, M_AXI_arprot}, 6'h0);
    arst = 1'b0;
    step();

    // Write, aw/w ready together one cycle after valid: each valid high exactly 2 cycles
    run_txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1, 1, 0, 2'b00, 0, 1'b0, aw_c, w_c);
    check("t1_awvalid_cycles", aw_c, 2);
    check("t1_wvalid_cycles", w_c, 2);

    // Write with wready three cycles ahead of awready
    run_txn(1'b1, 32'h1000_000C, 32'hA5A5_0F0F, 4'h5, 3, 0, 0, 2'b00, 0, 1'b0, aw_c, w_c);
    check("t2_awvalid_cycles", aw_c, 4);
    check("t2_wvalid_cycles", w_c, 1);

    // Read with arready delayed 4 cycles and SLVERR
    slv_mem[4] = 32'h1234_5678;
    ref_mem[4] = 32'h1234_5678;
    run_txn(1'b0, 32'h1000_0010, 32'h0, 4'h0, 4, 0, 1, 2'b10, 0, 1'b0, aw_c, w_c);
    check("t3_arvalid_cycles", aw_c, 5);

    // Response held 5 cycles with a second command pending, then that command runs
    run_txn(1'b0, 32'h1000_0004, 32'h0, 4'h0, 0, 0, 0, 2'b11, 5, 1'b1, aw_c, w_c);
    check("t4_pending_valid", cmd_valid, 1'b1);
    run_txn(1'b1, 32'h1000_0008, 32'h0BAD_F00D, 4'h3, 0, 2, 3, 2'b00, 0, 1'b0, aw_c, w_c);
    run_txn(1'b0, 32'h1000_0008, 32'h0, 4'h0, 1, 0, 2, 2'b00, 0, 1'b0, aw_c, w_c);

    // Reset in the middle of a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1000_0020;
    cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    check("t5_awvalid_before", M_AXI_awvalid, 1'b1);
    arst = 1'b1;
    #1;
    check("t5_awvalid_async", M_AXI_awvalid, 1'b0);
    check("t5_wvalid_async", M_AXI_wvalid, 1'b0);
    check("t5_cmd_ready_async", cmd_ready, 1'b1);
    check("t5_in_transaction_async", in_transaction, 1'b0);
    check("t5_rsp_valid_async", rsp_valid, 1'b0);
    step();
    arst = 1'b0;
    step();
    check("t5_no_response", rsp_valid, 1'b0);
    run_txn(1'b1, 32'h1000_0020, 32'h7777_8888, 4'hC, 0, 0, 0, 2'b00, 0, 1'b0, aw_c, w_c);
    run_txn(1'b0, 32'h1000_0020, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 1'b0, aw_c, w_c);

    // Back-to-back random traffic against the reference memory
    for (int t = 0; t < 100; t++) begin
      wr    = 1'($urandom_range(1));
      ridx  = 4'($urandom_range(15));
      rdat  = $urandom;
      rstrb = 4'($urandom_range(15));
      run_txn(wr, {26'h040_0000, ridx, 2'b00}, rdat, rstrb,
              int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
              2'($urandom_range(3)), int'($urandom_range(2)), 1'b0, aw_c, w_c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
